// File: rtl/spi_sched_pkg.sv
// Shared encodings for the SPI transmit scheduler: FSM states, RX command codes,
// arbitration modes and a saturating counter helper.
package spi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARB   = 2'b01,
        ST_OFFER = 2'b10,
        ST_XFER  = 2'b11
    } state_e;

    localparam logic [1:0] CMD_RR      = 2'b00;
    localparam logic [1:0] CMD_FIXED   = 2'b01;
    localparam logic [1:0] CMD_STICKY  = 2'b10;
    localparam logic [1:0] CMD_PTR_CLR = 2'b11;

    localparam logic [1:0] MODE_RR     = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_STICKY = 2'b10;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N_CH-way arbiter: rotating-pointer round-robin, fixed lowest-index
// priority, or sticky re-grant of the last channel with round-robin fallback.
module rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int IW   = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    input  logic [1:0]      i_mode,
    input  logic [IW-1:0]   i_last,
    output logic [N_CH-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic found_s;

    function automatic int wrap_add(input int a, input int b);
        return (a + b >= N_CH) ? (a + b - N_CH) : (a + b);
    endfunction

    // grant selection for the current mode
    always_comb begin
        found_s = 1'b0;
        o_idx   = {IW{1'b0}};
        o_any   = |i_req;
        if (i_mode == MODE_FIXED) begin
            for (int i = 0; i < N_CH; i++) begin
                if (i_req[i] && !found_s) begin
                    found_s = 1'b1;
                    o_idx   = IW'(i);
                end else begin
                    found_s = found_s;
                end
            end
        end else if ((i_mode == MODE_STICKY) && i_req[i_last]) begin
            found_s = 1'b1;
            o_idx   = i_last;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (i_req[wrap_add(int'(i_ptr), i)] && !found_s) begin
                    found_s = 1'b1;
                    o_idx   = IW'(wrap_add(int'(i_ptr), i));
                end else begin
                    found_s = found_s;
                end
            end
        end
        o_gnt = found_s ? ({{(N_CH-1){1'b0}}, 1'b1} << o_idx) : {N_CH{1'b0}};
    end

endmodule

// File: rtl/spi_tx_sched.sv
// SPI slave transmit scheduler: arbitrates producer channels into one word per frame
// and decodes the RX command of each frame to pick the arbitration mode.
module spi_tx_sched
    import spi_sched_pkg::*;
#(
    parameter int                   N_CH      = 4,
    parameter int                   DATA_BITS = 16,
    parameter int                   CMD_BITS  = 2,
    parameter int                   TIMEOUT   = 255,
    parameter logic [DATA_BITS-1:0] FILL      = {DATA_BITS{1'b1}}
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_CH*DATA_BITS-1:0] i_ch_data,
    input  logic [N_CH-1:0]           i_ch_valid,
    output logic [N_CH-1:0]           o_ch_ack,
    input  logic                      i_tx_req,
    input  logic                      i_busy,
    input  logic [CMD_BITS-1:0]       i_rx_buff,
    output logic [DATA_BITS-1:0]      o_tx_data,
    output logic                      o_tx_valid,
    output logic [$clog2(N_CH):0]     o_frame_ch,
    output logic [1:0]                o_mode,
    output logic [7:0]                o_abort_cnt
);

    localparam int IW = $clog2(N_CH);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_e               state_r, state_nxt_s;
    logic [IW-1:0]        ptr_r, ptr_nxt_s;
    logic [IW-1:0]        last_r, last_nxt_s;
    logic [1:0]           mode_r, mode_nxt_s;
    logic [WW-1:0]        wait_r, wait_nxt_s;
    logic [7:0]           abort_r, abort_nxt_s;
    logic [DATA_BITS-1:0] tx_data_r, tx_data_nxt_s;
    logic                 tx_valid_r, tx_valid_nxt_s;
    logic [IW:0]          frame_r, frame_nxt_s;
    logic [N_CH-1:0]      ack_r, ack_nxt_s;
    logic                 cap_pend_r, cap_pend_nxt_s;

    logic [N_CH-1:0]      gnt_s;
    logic [IW-1:0]        gidx_s;
    logic                 any_s;
    logic [1:0]           cmd_s;

    rr_arbiter #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_arb (
        .i_req  (i_ch_valid),
        .i_ptr  (ptr_r),
        .i_mode (mode_r),
        .i_last (last_r),
        .o_gnt  (gnt_s),
        .o_idx  (gidx_s),
        .o_any  (any_s)
    );

    assign cmd_s = i_rx_buff[1:0];

    // next-state, latching and counter decisions
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        last_nxt_s     = last_r;
        mode_nxt_s     = mode_r;
        wait_nxt_s     = wait_r;
        abort_nxt_s    = abort_r;
        tx_data_nxt_s  = tx_data_r;
        frame_nxt_s    = frame_r;
        ack_nxt_s      = {N_CH{1'b0}};
        cap_pend_nxt_s = cap_pend_r;
        case (state_r)
            ST_IDLE: begin
                if (i_tx_req) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!i_tx_req) begin
                    state_nxt_s = ST_IDLE;
                    abort_nxt_s = sat_inc8(abort_r);
                    wait_nxt_s  = {WW{1'b0}};
                end else if (any_s) begin
                    state_nxt_s   = ST_OFFER;
                    ack_nxt_s     = gnt_s;
                    tx_data_nxt_s = i_ch_data[int'(gidx_s)*DATA_BITS +: DATA_BITS];
                    frame_nxt_s   = {1'b0, gidx_s};
                    last_nxt_s    = gidx_s;
                    ptr_nxt_s     = (gidx_s == IW'(N_CH - 1)) ? {IW{1'b0}} : gidx_s + IW'(1);
                    wait_nxt_s    = {WW{1'b0}};
                end else if (wait_r == WW'(TIMEOUT - 1)) begin
                    state_nxt_s   = ST_OFFER;
                    tx_data_nxt_s = FILL;
                    frame_nxt_s   = {1'b1, {IW{1'b0}}};
                    wait_nxt_s    = {WW{1'b0}};
                end else begin
                    wait_nxt_s = wait_r + WW'(1);
                end
            end
            ST_OFFER: begin
                if (i_busy) begin
                    state_nxt_s = ST_XFER;
                end else if (!i_tx_req) begin
                    state_nxt_s = ST_IDLE;
                    abort_nxt_s = sat_inc8(abort_r);
                end else begin
                    state_nxt_s = ST_OFFER;
                end
            end
            ST_XFER: begin
                // RX word is sampled one cycle after busy is first seen low
                if (cap_pend_r) begin
                    cap_pend_nxt_s = 1'b0;
                    state_nxt_s    = ST_IDLE;
                    case (cmd_s)
                        CMD_RR:      mode_nxt_s = MODE_RR;
                        CMD_FIXED:   mode_nxt_s = MODE_FIXED;
                        CMD_STICKY:  mode_nxt_s = MODE_STICKY;
                        CMD_PTR_CLR: ptr_nxt_s  = {IW{1'b0}};
                        default:     mode_nxt_s = mode_r;
                    endcase
                end else if (!i_busy) begin
                    cap_pend_nxt_s = 1'b1;
                end else begin
                    cap_pend_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        tx_valid_nxt_s = (state_nxt_s == ST_OFFER);
    end

    // state and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IW{1'b0}};
            last_r     <= {IW{1'b0}};
            mode_r     <= MODE_RR;
            wait_r     <= {WW{1'b0}};
            abort_r    <= 8'd0;
            tx_data_r  <= {DATA_BITS{1'b0}};
            tx_valid_r <= 1'b0;
            frame_r    <= {(IW+1){1'b0}};
            ack_r      <= {N_CH{1'b0}};
            cap_pend_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            last_r     <= last_nxt_s;
            mode_r     <= mode_nxt_s;
            wait_r     <= wait_nxt_s;
            abort_r    <= abort_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            frame_r    <= frame_nxt_s;
            ack_r      <= ack_nxt_s;
            cap_pend_r <= cap_pend_nxt_s;
        end
    end

    assign o_ch_ack    = ack_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_valid  = tx_valid_r;
    assign o_frame_ch  = frame_r;
    assign o_mode      = mode_r;
    assign o_abort_cnt = abort_r;

endmodule

// File: tb/tb_spi_tx_sched.sv
// Randomised frame-level bench for spi_tx_sched with an in-bench scheduler model,
// plus directed frames pinned to hand-computed values.
module tb_spi_tx_sched;

    localparam int N_CH      = 4;
    localparam int DATA_BITS = 16;
    localparam int CMD_BITS  = 2;
    localparam int TIMEOUT   = 255;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [N_CH*DATA_BITS-1:0] ch_data;
    logic [N_CH-1:0]           ch_valid;
    logic [N_CH-1:0]           ch_ack;
    logic                      tx_req;
    logic                      busy;
    logic [CMD_BITS-1:0]       rx_buff;
    logic [DATA_BITS-1:0]      tx_data;
    logic                      tx_valid;
    logic [2:0]                frame_ch;
    logic [1:0]                mode;
    logic [7:0]                abort_cnt;

    always #5 clk = ~clk;

    spi_tx_sched #(
        .N_CH      (N_CH),
        .DATA_BITS (DATA_BITS),
        .CMD_BITS  (CMD_BITS),
        .TIMEOUT   (TIMEOUT),
        .FILL      (16'hFFFF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ch_data   (ch_data),
        .i_ch_valid  (ch_valid),
        .o_ch_ack    (ch_ack),
        .i_tx_req    (tx_req),
        .i_busy      (busy),
        .i_rx_buff   (rx_buff),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_frame_ch  (frame_ch),
        .o_mode      (mode),
        .o_abort_cnt (abort_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model state
    int              m_ptr, m_mode, m_last, m_abort;
    logic [15:0]     e_data;
    logic            e_valid;
    logic [2:0]      e_frame;
    logic [N_CH-1:0] e_ack;
    logic [15:0]     words [N_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N_CH; k++) ch_data[k*DATA_BITS +: DATA_BITS] = words[k];
    endtask

    // compare all outputs to the model at the falling edge, then advance one cycle
    task automatic step();
        @(negedge clk);
        chk("tx_data", 32'(tx_data), 32'(e_data));
        chk("tx_valid", 32'(tx_valid), 32'(e_valid));
        chk("frame_ch", 32'(frame_ch), 32'(e_frame));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
        chk("ch_ack", 32'(ch_ack), 32'(e_ack));
        @(posedge clk);
        #1;
        e_ack = '0;
    endtask

    function automatic int model_grant(input logic [N_CH-1:0] v);
        if (v == '0) return -1;
        if (m_mode == 1) begin
            for (int i = 0; i < N_CH; i++) if (v[i]) return i;
        end
        if (m_mode == 2 && v[m_last]) return m_last;
        for (int i = 0; i < N_CH; i++) if (v[(m_ptr + i) % N_CH]) return (m_ptr + i) % N_CH;
        return -1;
    endfunction

    // producer k supplies a fresh word after its ack; keep=1 holds it valid
    task automatic refill(input int k, input bit keep);
        words[k] = 16'($urandom);
        if (!keep) ch_valid[k] = ($urandom_range(0, 3) != 0);
        drive_bus();
    endtask

    // ARB phase; result 0 = aborted, 1 = granted, 2 = filler
    task automatic arb_phase(input int drop_at, input bit keep, input bit arrivals, output int res);
        int w = 0;
        int g;
        logic [15:0] wd;
        res = -1;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            if (c == drop_at) tx_req = 1'b0;
            if (!tx_req) begin
                step();
                m_abort = (m_abort == 255) ? 255 : m_abort + 1;
                res = 0;
                return;
            end
            g = model_grant(ch_valid);
            if (g >= 0) begin
                wd = words[g];
                step();
                e_ack   = '0;
                e_ack[g] = 1'b1;
                e_data  = wd;
                e_frame = {1'b0, 2'(g)};
                e_valid = 1'b1;
                m_ptr   = (g + 1) % N_CH;
                m_last  = g;
                refill(g, keep);
                res = 1;
                return;
            end
            w++;
            step();
            if (w == TIMEOUT) begin
                e_data  = 16'hFFFF;
                e_frame = 3'b100;
                e_valid = 1'b1;
                res = 2;
                return;
            end
            if (arrivals && $urandom_range(0, 7) == 0) begin
                g = $urandom_range(0, N_CH - 1);
                words[g] = 16'($urandom);
                ch_valid[g] = 1'b1;
                drive_bus();
            end
        end
        chk("arb_bound", 32'(res), 32'd1);
    endtask

    // one whole frame; got_* sample the DUT right after the grant edge
    task automatic frame(input int drop_at, input bit offer_abort, input logic [1:0] cmd,
                         input bit keep, output logic [2:0] got_frame, output logic [N_CH-1:0] got_ack);
        int res;
        tx_req = 1'b1;
        step();
        arb_phase(drop_at, keep, !keep, res);
        got_frame = frame_ch;
        got_ack   = ch_ack;
        if (res == 0) return;
        repeat ($urandom_range(0, 2)) step();
        if (offer_abort) begin
            tx_req = 1'b0;
            step();
            e_valid = 1'b0;
            m_abort = (m_abort == 255) ? 255 : m_abort + 1;
            return;
        end
        busy = 1'b1;
        step();
        e_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
            rx_buff = 2'($urandom);
            step();
        end
        busy    = 1'b0;
        tx_req  = 1'b0;
        rx_buff = ~cmd;
        step();
        rx_buff = cmd;
        step();
        case (cmd)
            2'b00: m_mode = 0;
            2'b01: m_mode = 1;
            2'b10: m_mode = 2;
            default: m_ptr = 0;
        endcase
    endtask

    task automatic set_valid(input logic [N_CH-1:0] v);
        ch_valid = v;
        for (int k = 0; k < N_CH; k++) words[k] = 16'($urandom);
        drive_bus();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
        $fatal(1);
    end

    initial begin
        logic [2:0]      gf;
        logic [N_CH-1:0] ga;
        m_ptr = 0; m_mode = 0; m_last = 0; m_abort = 0;
        e_data = '0; e_valid = 1'b0; e_frame = '0; e_ack = '0;
        rst = 1'b1; tx_req = 1'b0; busy = 1'b0; rx_buff = '0;
        ch_valid = '0;
        for (int k = 0; k < N_CH; k++) words[k] = 16'h0;
        drive_bus();
        step();
        step();
        chk("reset_outputs", {tx_data, 3'(tx_valid), frame_ch, mode, abort_cnt[5:0]}, 32'd0);
        rst = 1'b0;
        step();

        // round-robin, all valid
        set_valid(4'b1111);
        for (int i = 0; i < 5; i++) begin
            frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
            chk("rr_frame", 32'(gf), 32'(i % 4));
            chk("rr_ack", 32'(ga), 32'(4'b0001 << (i % 4)));
        end

        // fixed priority: ch1 always beats ch3
        frame(-1, 1'b0, 2'b01, 1'b1, gf, ga);
        chk("mode_fixed", 32'(mode), 32'd1);
        set_valid(4'b1010);
        for (int i = 0; i < 3; i++) begin
            frame(-1, 1'b0, 2'b01, 1'b1, gf, ga);
            chk("fixed_frame", 32'(gf), 32'd1);
            chk("fixed_ack", 32'(ga), 32'd2);
        end

        // sticky re-grant, then pointer clear
        set_valid(4'b0010);
        frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
        set_valid(4'b0100);
        frame(-1, 1'b0, 2'b10, 1'b1, gf, ga);
        chk("sticky_setup", 32'(gf), 32'd2);
        set_valid(4'b1111);
        frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
        chk("sticky_regrant", 32'(gf), 32'd2);
        set_valid(4'b0010);
        frame(-1, 1'b0, 2'b11, 1'b1, gf, ga);
        chk("ptrclr_setup", 32'(gf), 32'd1);
        set_valid(4'b1111);
        frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
        chk("ptrclr_grant", 32'(gf), 32'd0);

        // timeout twice: the wait counter must restart for the second frame
        set_valid(4'b0000);
        for (int i = 0; i < 2; i++) begin
            frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
            chk("timeout_frame", 32'(gf), 32'h4);
            chk("timeout_noack", 32'(ga), 32'd0);
        end
        chk("timeout_data", 32'(tx_data), 32'h0000FFFF);

        // single abort in OFFER
        set_valid(4'b0100);
        chk("abort_before", 32'(abort_cnt), 32'd0);
        frame(-1, 1'b1, 2'b00, 1'b1, gf, ga);
        chk("abort_after", 32'(abort_cnt), 32'd1);

        // randomised frames
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!ch_valid[k] && $urandom_range(0, 2) == 0) begin
                    ch_valid[k] = 1'b1;
                    words[k] = 16'($urandom);
                end
            end
            drive_bus();
            frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 7) == 0), 2'($urandom), 1'b0, gf, ga);
            repeat ($urandom_range(0, 2)) step();
        end

        // reset while in XFER with a non-default mode
        set_valid(4'b1111);
        frame(-1, 1'b0, 2'b01, 1'b1, gf, ga);
        tx_req = 1'b1;
        step();
        begin
            int res;
            arb_phase(-1, 1'b1, 1'b0, res);
        end
        busy = 1'b1;
        step();
        e_valid = 1'b0;
        rst = 1'b1;
        #1;
        m_ptr = 0; m_mode = 0; m_last = 0; m_abort = 0;
        e_data = '0; e_valid = 1'b0; e_frame = '0; e_ack = '0;
        chk("rst_mid_outputs", {tx_data, 3'(tx_valid), frame_ch, mode, abort_cnt[5:0]}, 32'd0);
        chk("rst_mid_ack", 32'(ch_ack), 32'd0);
        busy = 1'b0;
        tx_req = 1'b0;
        step();
        rst = 1'b0;
        step();
        frame(-1, 1'b0, 2'b00, 1'b1, gf, ga);
        chk("post_rst_grant", 32'(gf), 32'd0);

        // 300 aborts saturate the counter
        for (int i = 0; i < 300; i++) frame(0, 1'b0, 2'b00, 1'b1, gf, ga);
        chk("abort_sat", 32'(abort_cnt), 32'd255);
        frame(-1, 1'b1, 2'b00, 1'b1, gf, ga);
        chk("abort_sat_hold", 32'(abort_cnt), 32'd255);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
